cirno9_mem_arb: RTL and testbench

Parametrised N-channel memory-port arbiter; successor to the fixed fetch/load-store/slave muxing inside the core's LSU. Accepts val/rdy requests from NCH requesters (fetch, AG, AXI slave, future DMA), grants one per cycle round-robin onto a single 1-cycle-latency SRAM port, and routes read data back to the originating channel. A one-entry response hold buffer handles requesters that are not ready to take their response.

---
 rtl/cirno9_mem_arb.sv | 175 +++++++++++++++++
 tb/tb_cirno9_mem_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cirno9_mem_arb.sv
// cirno9_mem_arb -- N-channel round-robin arbiter onto one SRAM port.
//
// Requesters present val/rdy requests. At most one request is granted per
// cycle and drives the SRAM port in that same cycle. Read data returns one
// cycle later and is routed to the originating channel. A one-entry hold
// buffer keeps a response that its requester could not take yet. While a
// response is outstanding and not being taken, all grants are blocked.
//
// Optional feature macro: CIRNO_ARB_PRIO0_EN
//   defined   : channel 0 has fixed top priority. Channels 1..NCH-1 share
//               round-robin among themselves.
//   undefined : pure round-robin over all channels.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   i_req_val    per-channel request valid
//   o_req_rdy    per-channel request accepted (one-hot or zero)
//   i_req_adr    packed addresses, channel c at [c*AW +: AW]
//   i_req_wdat   packed write data, channel c at [c*DW +: DW]
//   i_req_wen    packed byte enables, channel c at [c*BW +: BW]
//   i_req_ren    per-channel read enable
//   o_rsp_val    per-channel response valid (at most one bit set)
//   i_rsp_rdy    per-channel response ready
//   o_rsp_rdat   shared response data, 0 when no response is valid
//   o_sram_*     SRAM port, all 0 when nothing is granted
//   i_sram_rdat  SRAM read data, valid the cycle after a read
module cirno9_mem_arb #(
  parameter int NCH = 3,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          i_req_val,
  output logic [NCH-1:0]          o_req_rdy,
  input  logic [NCH*AW-1:0]       i_req_adr,
  input  logic [NCH*DW-1:0]       i_req_wdat,
  input  logic [NCH*(DW/8)-1:0]   i_req_wen,
  input  logic [NCH-1:0]          i_req_ren,
  output logic [NCH-1:0]          o_rsp_val,
  input  logic [NCH-1:0]          i_rsp_rdy,
  output logic [DW-1:0]           o_rsp_rdat,
  output logic                    o_sram_val,
  output logic                    o_sram_ren,
  output logic [DW/8-1:0]         o_sram_wen,
  output logic [AW-1:0]           o_sram_adr,
  output logic [DW-1:0]           o_sram_wdat,
  input  logic [DW-1:0]           i_sram_rdat
);
  localparam int BW = DW / 8;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0] r_rr_ptr;
  logic          r_p_vld;
  logic [PW-1:0] r_p_ch;
  logic          r_h_vld;
  logic [PW-1:0] r_h_ch;
  logic [DW-1:0] r_h_dat;

  logic          w_stall;
  logic          w_gnt_vld;
  logic [PW-1:0] w_gnt_ch;
  logic          w_rr_upd;
  logic [PW-1:0] w_nxt_ptr;
  logic [BW-1:0] w_wen;
  logic          w_is_wr;
  logic          w_is_rd;
  int            w_idx;

  // An outstanding response that is not being taken blocks every grant;
  // the held-buffer case always blocks, even in the cycle it drains.
  assign w_stall = r_h_vld | (r_p_vld & ~i_rsp_rdy[r_p_ch]);

  // Scan from the highest offset down so the lowest offset from the pointer
  // is the last assignment and wins.
`ifdef CIRNO_ARB_PRIO0_EN
  int w_base;
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    w_rr_upd  = 1'b0;
    w_idx     = 0;
    // Pointer value 0 (reset) is treated as "start at channel 1".
    w_base    = (r_rr_ptr == '0) ? 0 : int'(r_rr_ptr) - 1;
    for (int k = NCH - 2; k >= 0; k--) begin
      w_idx = 1 + ((w_base + k) % (NCH - 1));
      if (i_req_val[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = PW'(w_idx);
        w_rr_upd  = 1'b1;
      end
    end
    if (i_req_val[0]) begin
      w_gnt_vld = 1'b1;
      w_gnt_ch  = '0;
      w_rr_upd  = 1'b0;
    end
    if (rst || w_stall) begin
      w_gnt_vld = 1'b0;
      w_rr_upd  = 1'b0;
    end
  end
`else
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    w_rr_upd  = 1'b0;
    w_idx     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % NCH;
      if (i_req_val[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = PW'(w_idx);
        w_rr_upd  = 1'b1;
      end
    end
    if (rst || w_stall) begin
      w_gnt_vld = 1'b0;
      w_rr_upd  = 1'b0;
    end
  end
`endif

  assign w_nxt_ptr = PW'((int'(w_gnt_ch) + 1) % NCH);
  assign w_wen     = i_req_wen[int'(w_gnt_ch)*BW +: BW];
  // A nonzero byte enable makes it a write regardless of ren.
  assign w_is_wr   = w_gnt_vld & (|w_wen);
  assign w_is_rd   = w_gnt_vld & ~(|w_wen) & i_req_ren[w_gnt_ch];

  always_comb begin
    o_req_rdy = '0;
    if (w_gnt_vld) o_req_rdy[w_gnt_ch] = 1'b1;
    o_sram_val  = w_is_wr | w_is_rd;
    o_sram_ren  = w_is_rd;
    o_sram_wen  = w_is_wr ? w_wen : '0;
    o_sram_adr  = w_gnt_vld ? i_req_adr[int'(w_gnt_ch)*AW +: AW] : '0;
    o_sram_wdat = w_gnt_vld ? i_req_wdat[int'(w_gnt_ch)*DW +: DW] : '0;
  end

  // Held response takes precedence; the hold buffer and an in-flight read
  // are never both valid because capturing into the hold buffer stalls.
  always_comb begin
    o_rsp_val  = '0;
    o_rsp_rdat = '0;
    if (r_h_vld) begin
      o_rsp_val[r_h_ch] = 1'b1;
      o_rsp_rdat        = r_h_dat;
    end else if (r_p_vld) begin
      o_rsp_val[r_p_ch] = 1'b1;
      o_rsp_rdat        = i_sram_rdat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_p_vld  <= 1'b0;
      r_p_ch   <= '0;
      r_h_vld  <= 1'b0;
      r_h_ch   <= '0;
      r_h_dat  <= '0;
    end else begin
      if (w_rr_upd) r_rr_ptr <= w_nxt_ptr;
      r_p_vld <= w_is_rd;
      if (w_is_rd) r_p_ch <= w_gnt_ch;
      if (r_h_vld) begin
        if (i_rsp_rdy[r_h_ch]) r_h_vld <= 1'b0;
      end else if (r_p_vld && !i_rsp_rdy[r_p_ch]) begin
        r_h_vld <= 1'b1;
        r_h_ch  <= r_p_ch;
        r_h_dat <= i_sram_rdat;
      end
    end
  end
endmodule

// File: tb/tb_cirno9_mem_arb.sv
// Testbench for cirno9_mem_arb (NCH=3, AW=32, DW=32) with a behavioural
// 1-cycle-latency SRAM. Word i initially holds 0xA000_0000 | i, except
// word 4 (address 0x10), which holds 0x1234_5678.
module tb_cirno9_mem_arb;
`ifdef CIRNO_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_val, req_ren, rsp_rdy;
  logic [2:0]  req_rdy, rsp_val;
  logic [95:0] req_adr, req_wdat;
  logic [11:0] req_wen;
  logic [31:0] rsp_rdat, sram_adr, sram_wdat;
  logic [31:0] sram_rdat = 32'h0;
  logic        sram_val, sram_ren;
  logic [3:0]  sram_wen;

  logic [31:0] mem [256];
  logic        mem_init = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic [2:0]  val, ren, rdy;
    logic [11:0] wen;
    logic [95:0] adr;
    logic [31:0] wdat;
    logic [2:0]  e_rdy, e_rsp;
    logic [31:0] e_rdat;
    logic        e_sval, e_sren;
    logic [3:0]  e_swen;
    logic [31:0] e_sadr;
  } vec_t;

  localparam logic [95:0] ADR  = {32'h8,  32'h4,  32'h0};
  localparam logic [95:0] ADRH = {32'h8,  32'h10, 32'h0};
  localparam logic [95:0] ADRW = {32'h20, 32'h4,  32'h0};

  vec_t tbl [9];

  cirno9_mem_arb #(.NCH(3), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_val(req_val), .o_req_rdy(req_rdy),
    .i_req_adr(req_adr), .i_req_wdat(req_wdat),
    .i_req_wen(req_wen), .i_req_ren(req_ren),
    .o_rsp_val(rsp_val), .i_rsp_rdy(rsp_rdy), .o_rsp_rdat(rsp_rdat),
    .o_sram_val(sram_val), .o_sram_ren(sram_ren), .o_sram_wen(sram_wen),
    .o_sram_adr(sram_adr), .o_sram_wdat(sram_wdat), .i_sram_rdat(sram_rdat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem[4]   <= 32'h1234_5678;
      mem_init <= 1'b1;
    end else if (sram_val) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_adr[9:2]][b*8 +: 8] <= sram_wdat[b*8 +: 8];
      if (sram_ren) sram_rdat <= mem[sram_adr[9:2]];
    end
  end

  function automatic vec_t mk(string nm, logic [2:0] val, logic [2:0] ren,
                              logic [2:0] rdy, logic [11:0] wen,
                              logic [95:0] adr, logic [31:0] wdat,
                              logic [2:0] e_rdy, logic [2:0] e_rsp,
                              logic [31:0] e_rdat, logic e_sval, logic e_sren,
                              logic [3:0] e_swen, logic [31:0] e_sadr);
    vec_t v;
    v.nm = nm; v.val = val; v.ren = ren; v.rdy = rdy; v.wen = wen;
    v.adr = adr; v.wdat = wdat; v.e_rdy = e_rdy; v.e_rsp = e_rsp;
    v.e_rdat = e_rdat; v.e_sval = e_sval; v.e_sren = e_sren;
    v.e_swen = e_swen; v.e_sadr = e_sadr;
    return v;
  endfunction

  function automatic vec_t idle(string nm, logic [2:0] rdy, logic [2:0] e_rsp,
                                logic [31:0] e_rdat);
    return mk(nm, 3'b000, 3'b000, rdy, 12'h0, ADR, 32'h0,
              3'b000, e_rsp, e_rdat, 1'b0, 1'b0, 4'h0, 32'h0);
  endfunction

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    req_val  = v.val;
    req_ren  = v.ren;
    rsp_rdy  = v.rdy;
    req_wen  = v.wen;
    req_adr  = v.adr;
    req_wdat = {3{v.wdat}};
    #1;
    chk(v.nm, "req_rdy",   32'(req_rdy),  32'(v.e_rdy));
    chk(v.nm, "rsp_val",   32'(rsp_val),  32'(v.e_rsp));
    chk(v.nm, "rsp_rdat",  rsp_rdat,      v.e_rdat);
    chk(v.nm, "sram_val",  32'(sram_val), 32'(v.e_sval));
    chk(v.nm, "sram_ren",  32'(sram_ren), 32'(v.e_sren));
    chk(v.nm, "sram_wen",  32'(sram_wen), 32'(v.e_swen));
    chk(v.nm, "sram_adr",  sram_adr,      v.e_sadr);
  endtask

  task automatic zero_inputs();
    req_val = '0; req_ren = '0; rsp_rdy = '0;
    req_wen = '0; req_adr = '0; req_wdat = '0;
  endtask

  initial begin
    int g, pv;
    // Round-robin table: one lone ch0 read, then all three channels reading.
    tbl[0] = mk("rd0", 3'b001, 3'b111, 3'b111, 12'h0, ADR, 32'h0,
                3'b001, 3'b000, 32'h0, 1'b1, 1'b1, 4'h0, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      g  = PRIO ? 0 : i % 3;
      pv = PRIO ? 0 : (i - 1) % 3;
      tbl[i] = mk($sformatf("rr%0d", i), 3'b111, 3'b111, 3'b111, 12'h0, ADR,
                  32'h0, 3'(1 << g), 3'(1 << pv), 32'hA000_0000 | 32'(pv),
                  1'b1, 1'b1, 4'h0, 32'(g * 4));
    end
    tbl[7] = idle("drain", 3'b111, 3'b001, 32'hA000_0000);
    tbl[8] = idle("quiet", 3'b111, 3'b000, 32'h0);

    // Reset with random inputs: every output must be 0.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_val  = 3'($urandom);  req_ren = 3'($urandom);
      rsp_rdy  = 3'($urandom);  req_wen = 12'($urandom);
      req_adr  = {$urandom, $urandom, $urandom};
      req_wdat = {$urandom, $urandom, $urandom};
      #1;
      chk("reset", "req_rdy",  32'(req_rdy),  32'h0);
      chk("reset", "rsp_val",  32'(rsp_val),  32'h0);
      chk("reset", "rsp_rdat", rsp_rdat,      32'h0);
      chk("reset", "sram_val", 32'(sram_val), 32'h0);
      chk("reset", "sram_wen", 32'(sram_wen), 32'h0);
      chk("reset", "sram_adr", sram_adr,      32'h0);
    end
    @(negedge clk);
    zero_inputs();
    rst = 1'b0;

    foreach (tbl[i]) run(tbl[i]);

    // Response hold: ch1 not ready for three cycles.
    run(mk("hold_iss", 3'b010, 3'b010, 3'b101, 12'h0, ADRH, 32'h0,
           3'b010, 3'b000, 32'h0, 1'b1, 1'b1, 4'h0, 32'h10));
    for (int i = 1; i <= 3; i++)
      run(mk($sformatf("hold%0d", i), 3'b111, 3'b111, 3'b101, 12'h0, ADRH,
             32'h0, 3'b000, 3'b010, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 32'h0));
    run(mk("hold_take", 3'b111, 3'b111, 3'b111, 12'h0, ADRH, 32'h0,
           3'b000, 3'b010, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 32'h0));
    run(mk("resume", 3'b100, 3'b100, 3'b111, 12'h0, ADR, 32'h0,
           3'b100, 3'b000, 32'h0, 1'b1, 1'b1, 4'h0, 32'h8));
    run(idle("resume_rsp", 3'b111, 3'b100, 32'hA000_0002));

    // Partial write with ren also set, then read back; then a no-op accept.
    run(mk("wr", 3'b100, 3'b100, 3'b111, {4'b0011, 8'h0}, ADRW, 32'hDEAD_BEEF,
           3'b100, 3'b000, 32'h0, 1'b1, 1'b0, 4'b0011, 32'h20));
    run(idle("wr_norsp", 3'b111, 3'b000, 32'h0));
    run(mk("rd_wr", 3'b100, 3'b100, 3'b111, 12'h0, ADRW, 32'h0,
           3'b100, 3'b000, 32'h0, 1'b1, 1'b1, 4'h0, 32'h20));
    run(idle("rd_wr_rsp", 3'b111, 3'b100, 32'hA000_BEEF));
    run(mk("nop_acc", 3'b001, 3'b000, 3'b111, 12'h0, ADR, 32'h0,
           3'b001, 3'b000, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0));
    run(idle("nop_norsp", 3'b111, 3'b000, 32'h0));

    // Asynchronous reset while a response is held.
    run(mk("rst_iss", 3'b010, 3'b010, 3'b101, 12'h0, ADRH, 32'h0,
           3'b010, 3'b000, 32'h0, 1'b1, 1'b1, 4'h0, 32'h10));
    run(idle("rst_p", 3'b101, 3'b010, 32'h1234_5678));
    run(idle("rst_h", 3'b101, 3'b010, 32'h1234_5678));
    #1 rst = 1'b1;
    #1;
    chk("rst_async", "rsp_val",  32'(rsp_val), 32'h0);
    chk("rst_async", "rsp_rdat", rsp_rdat,     32'h0);
    chk("rst_async", "req_rdy",  32'(req_rdy), 32'h0);
    zero_inputs();
    @(negedge clk);
    rst = 1'b0;
    run(idle("rst_after1", 3'b111, 3'b000, 32'h0));
    run(idle("rst_after2", 3'b111, 3'b000, 32'h0));

    // ch0 and ch1 continuously valid, pointer back at 0 after reset.
    run(mk("alt0", 3'b011, 3'b011, 3'b111, 12'h0, ADR, 32'h0,
           3'b001, 3'b000, 32'h0, 1'b1, 1'b1, 4'h0, 32'h0));
    if (PRIO) begin
      for (int i = 1; i <= 3; i++)
        run(mk($sformatf("alt%0d", i), 3'b011, 3'b011, 3'b111, 12'h0, ADR,
               32'h0, 3'b001, 3'b001, 32'hA000_0000, 1'b1, 1'b1, 4'h0, 32'h0));
      run(idle("alt_drain", 3'b111, 3'b001, 32'hA000_0000));
    end else begin
      run(mk("alt1", 3'b011, 3'b011, 3'b111, 12'h0, ADR, 32'h0,
             3'b010, 3'b001, 32'hA000_0000, 1'b1, 1'b1, 4'h0, 32'h4));
      run(mk("alt2", 3'b011, 3'b011, 3'b111, 12'h0, ADR, 32'h0,
             3'b001, 3'b010, 32'hA000_0001, 1'b1, 1'b1, 4'h0, 32'h0));
      run(mk("alt3", 3'b011, 3'b011, 3'b111, 12'h0, ADR, 32'h0,
             3'b010, 3'b001, 32'hA000_0000, 1'b1, 1'b1, 4'h0, 32'h4));
      run(idle("alt_drain", 3'b111, 3'b010, 32'hA000_0001));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
